// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for DVI/HDMI bring-up. Generates hsync/vsync/de
// plus colour bars, gray ramp, solid colour or checkerboard, all registered in pixelclk.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pixelclk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red_dout,
  output logic [7:0]  green_dout,
  output logic [7:0]  blue_dout,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_ACT_L    = 12'(H_ACTIVE);
  localparam logic [11:0] H_MAX      = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_L    = 12'(V_ACTIVE);
  localparam logic [11:0] V_MAX      = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        frame_origin;
  pattern_e    pat_q;
  pattern_e    pat_now;

  assign h_last       = (h_cnt == H_MAX);
  assign v_last       = (v_cnt == V_MAX);
  assign frame_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_last) begin
      h_cnt <= 12'd0;
      v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // The pattern is captured at pixel (0,0) and used for that pixel too, so a change
  // appears exactly at the next frame_start and never tears mid-frame.
  assign pat_now = frame_origin ? pattern_e'(pattern_sel) : pat_q;

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      pat_q <= PAT_BARS;
    end else if (frame_origin) begin
      pat_q <= pattern_e'(pattern_sel);
    end
  end

  logic        active_d;
  logic        hs_d;
  logic        vs_d;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] rgb_d;

  // Bar index by comparing against the seven bar edges, avoiding a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = C_WHITE;
      3'd1:    bar_rgb = C_YELLOW;
      3'd2:    bar_rgb = C_CYAN;
      3'd3:    bar_rgb = C_GREEN;
      3'd4:    bar_rgb = C_MAGENTA;
      3'd5:    bar_rgb = C_RED;
      3'd6:    bar_rgb = C_BLUE;
      default: bar_rgb = C_BLACK;
    endcase
  end

  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    active_d = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    hs_d     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_d     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    rgb_d    = C_BLACK;
    if (active_d) begin
      unique case (pat_now)
        PAT_BARS:  rgb_d = bar_rgb;
        PAT_RAMP:  rgb_d = {3{h_cnt[7:0]}};
        PAT_SOLID: rgb_d = solid_rgb;
        PAT_CHECK: rgb_d = (h_cnt[5] ^ v_cnt[5]) ? C_BLACK : C_WHITE;
        default:   rgb_d = C_BLACK;
      endcase
    end
  end

  // Output register stage: everything presented one cycle after the counters.
  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      x_pos       <= 12'd0;
      y_pos       <= 12'd0;
      red_dout    <= 8'd0;
      green_dout  <= 8'd0;
      blue_dout   <= 8'd0;
    end else begin
      de          <= active_d;
      hsync       <= hs_d ? HS_POL : ~HS_POL;
      vsync       <= vs_d ? VS_POL : ~VS_POL;
      frame_start <= frame_origin;
      x_pos       <= active_d ? h_cnt : 12'd0;
      y_pos       <= active_d ? v_cnt : 12'd0;
      red_dout    <= rgb_d[23:16];
      green_dout  <= rgb_d[15:8];
      blue_dout   <= rgb_d[7:0];
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 24x12 raster: the stimulus side predicts each
// output cycle from a pixel index, the monitor pops and compares on the falling edge.
module tb_video_timing_gen;

  localparam int HT = 24;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;

  logic        pixelclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red_dout, green_dout, blue_dout;
  logic [11:0] x_pos, y_pos;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixelclk   (pixelclk),
    .rst_n      (rst_n),
    .pattern_sel(pattern_sel),
    .solid_rgb  (solid_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .red_dout   (red_dout),
    .green_dout (green_dout),
    .blue_dout  (blue_dout),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frame_start(frame_start)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] rgb;
  } out_t;

  out_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          nxt = 0;
  logic [1:0]  pat = 2'd0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and push the output the DUT should present after this edge.
  task automatic step(input logic r, input logic [1:0] sel, input logic [23:0] rgb);
    out_t e;
    int   c, l;
    rst_n       = r;
    pattern_sel = sel;
    solid_rgb   = rgb;
    @(posedge pixelclk);
    e = '0;
    if (!r) begin
      nxt = 0;
      pat = 2'd0;
    end else begin
      if (nxt == 0) pat = sel;
      c    = nxt % HT;
      l    = nxt / HT;
      e.de = (c < 16) && (l < 8);
      e.hs = (c == 18) || (c == 19);
      e.vs = (l == 9);
      e.fs = (c == 0) && (l == 0);
      if (e.de) begin
        e.x = 12'(c);
        e.y = 12'(l);
        case (pat)
          2'd0:    e.rgb = bars[c / 2];
          2'd1:    e.rgb = {3{8'(c)}};
          2'd2:    e.rgb = rgb;
          default: e.rgb = 24'hFFFFFF;
        endcase
      end
      nxt = (nxt + 1) % FRAME;
    end
    exp_q.push_back(e);
    #1;
  endtask

  // Selects sel_a until the pixel index reaches sw, then sel_b.
  task automatic run(input int n, input logic [1:0] sel_a, input logic [1:0] sel_b,
                     input int sw, input logic [23:0] rgb);
    for (int i = 0; i < n; i++) step(1'b1, (nxt < sw) ? sel_a : sel_b, rgb);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge pixelclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("de",          24'(de),          24'(e.de));
        check("hsync",       24'(hsync),       24'(e.hs));
        check("vsync",       24'(vsync),       24'(e.vs));
        check("frame_start", 24'(frame_start), 24'(e.fs));
        check("x_pos",       24'(x_pos),       24'(e.x));
        check("y_pos",       24'(y_pos),       24'(e.y));
        check("rgb",         {red_dout, green_dout, blue_dout}, e.rgb);
      end
    end
  end

  initial begin : stimulus
    step(1'b0, 2'd0, 24'h0);
    step(1'b0, 2'd0, 24'h0);
    run(FRAME, 2'd0, 2'd1, 50, 24'h0);            // bars; mid-frame change ignored
    run(FRAME, 2'd1, 2'd1, FRAME, 24'h0);         // gray ramp
    run(FRAME, 2'd2, 2'd2, FRAME, 24'h123456);    // solid
    run(FRAME, 2'd0, 2'd2, 3 * HT, 24'h123456);   // bars, switch to solid on line 3
    run(FRAME, 2'd2, 2'd2, FRAME, 24'hABCDEF);    // solid takes effect here
    run(4 * HT + 10, 2'd3, 2'd3, FRAME, 24'h0);   // checkerboard up to (10,4)
    step(1'b0, 2'd3, 24'h0);                      // one-cycle reset mid-frame
    run(30, 2'd3, 2'd3, FRAME, 24'h0);
    @(posedge pixelclk);
    @(negedge pixelclk);
    #1;
    check("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
